// File: rtl/pe_result_collector_if.sv
// Row stream and status bundle between the PE array side and the
// result collector; master drives rows and ready, slave returns the FIFO head.
interface pe_result_collector_if #(
   parameter int COLS  = 8,
   parameter int ACC_W = 32,
   parameter int DEPTH = 16
);
   logic                       data_flow;
   logic                       in_valid;
   logic [COLS*ACC_W-1:0]      in_row;
   logic                       out_valid;
   logic                       out_ready;
   logic [COLS*ACC_W-1:0]      out_data;
   logic                       out_last;
   logic [$clog2(DEPTH+1)-1:0] fill;
   logic [15:0]                tiles_done;
   logic                       overflow;
   logic                       len_err;

   modport master (
      output data_flow, in_valid, in_row, out_ready,
      input  out_valid, out_data, out_last, fill,
      input  tiles_done, overflow, len_err
   );

   modport slave (
      input  data_flow, in_valid, in_row, out_ready,
      output out_valid, out_data, out_last, fill,
      output tiles_done, overflow, len_err
   );
endinterface

// File: rtl/pe_result_collector.sv
// Frames PE result rows into tiles, buffers them in a row FIFO and
// flags drops and short OS tiles, since the array cannot be stalled.
module pe_result_collector #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int ACC_W    = 32,
   parameter int TILE_LEN = ROWS + COLS,
   parameter int DEPTH    = 16
) (
   input logic                  clk,
   input logic                  rst,
   pe_result_collector_if.slave bus
);
   localparam int RW = COLS * ACC_W;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(TILE_LEN);
   localparam logic [CW-1:0] LAST_IDX = CW'(TILE_LEN - 1);

   logic [RW-1:0] r_stage;
   logic          r_stage_v;
   logic          r_mode;
   logic [CW-1:0] r_row_cnt;
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [15:0]   r_tiles;
   logic          r_ovf;
   logic          r_len;
   logic [RW-1:0] r_mem [DEPTH];
   logic          r_mem_last [DEPTH];

   logic w_last;
   logic w_short;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_wr;
   logic w_drop;

   // r_row_cnt is the tile index of the row currently in the stage
   assign w_last  = r_stage_v &&
                    ((!r_mode && r_row_cnt == LAST_IDX) ||
                     !bus.in_valid);
   assign w_short = r_stage_v && !r_mode && !bus.in_valid &&
                    (r_row_cnt != LAST_IDX);
   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                    (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop   = !w_empty && bus.out_ready;
   assign w_wr    = r_stage_v && (!w_full || w_pop);
   assign w_drop  = r_stage_v && w_full && !w_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stage_v <= 1'b0;
         r_mode    <= 1'b0;
         r_row_cnt <= '0;
      end else begin
         r_stage_v <= bus.in_valid;
         if (!bus.in_valid) begin
            r_row_cnt <= '0;
         end else if (!r_stage_v) begin
            r_mode    <= bus.data_flow;
            r_row_cnt <= '0;
         end else if (w_last) begin
            r_row_cnt <= '0;
         end else begin
            r_row_cnt <= r_row_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid) r_stage <= bus.in_row;
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wp[AW-1:0]]      <= r_stage;
         r_mem_last[r_wp[AW-1:0]] <= w_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_tiles <= '0;
         r_ovf   <= 1'b0;
         r_len   <= 1'b0;
      end else begin
         if (w_wr)   r_wp    <= r_wp + 1'b1;
         if (w_pop)  r_rp    <= r_rp + 1'b1;
         // a dropped tail row still closes its tile
         if (w_last) r_tiles <= r_tiles + 16'd1;
         if (w_drop) r_ovf   <= 1'b1;
         if (w_short) r_len  <= 1'b1;
      end
   end

   assign bus.out_valid  = !w_empty;
   assign bus.out_data   = r_mem[r_rp[AW-1:0]];
   assign bus.out_last   = !w_empty && r_mem_last[r_rp[AW-1:0]];
   assign bus.fill       = r_wp - r_rp;
   assign bus.tiles_done = r_tiles;
   assign bus.overflow   = r_ovf;
   assign bus.len_err    = r_len;
endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: directed test-plan scenarios plus
// random traffic, all checked against a queue-based tile/FIFO model.
module tb_pe_result_collector;
   localparam int ROWS     = 8;
   localparam int COLS     = 8;
   localparam int ACC_W    = 32;
   localparam int TILE_LEN = ROWS + COLS;
   localparam int DEPTH    = 16;
   localparam int RW       = COLS * ACC_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_result_collector_if #(
      .COLS(COLS), .ACC_W(ACC_W), .DEPTH(DEPTH)
   ) bus ();

   pe_result_collector #(
      .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W),
      .TILE_LEN(TILE_LEN), .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_pops   = 0;

   typedef struct packed {
      logic          last;
      logic [RW-1:0] d;
   } ent_t;

   ent_t          q[$];
   bit            p_v;
   bit            p_os;
   logic [RW-1:0] p_d;
   int            p_idx;
   int            m_tiles;
   bit            m_ovf;
   bit            m_len;

   task automatic check(input string tag,
                        input logic [RW-1:0] got,
                        input logic [RW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] mkrow(input int val);
      logic [RW-1:0] r;
      for (int c = 0; c < COLS; c++) r[c*ACC_W +: ACC_W] = $urandom;
      r[ACC_W-1:0] = val;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      p_v     = 0;
      p_os    = 0;
      p_idx   = 0;
      m_tiles = 0;
      m_ovf   = 0;
      m_len   = 0;
   endtask

   // one clock of the reference: close the pending row, then FIFO
   task automatic model_edge(input bit v, input bit df,
                             input bit rdy, input logic [RW-1:0] row);
      bit   pop;
      bit   push;
      ent_t e;
      pop  = (q.size() > 0) && rdy;
      push = 0;
      e    = '0;
      if (p_v) begin
         push   = 1;
         e.d    = p_d;
         e.last = (p_os && p_idx == TILE_LEN - 1) || !v;
         if (e.last) m_tiles = (m_tiles + 1) % 65536;
         if (p_os && !v && p_idx != TILE_LEN - 1) m_len = 1;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
         if (q.size() < DEPTH) q.push_back(e);
         else m_ovf = 1;
      end
      if (v) begin
         if (!p_v) begin
            p_os  = !df;
            p_idx = 0;
         end else begin
            p_idx = e.last ? 0 : p_idx + 1;
         end
         p_d = row;
      end
      p_v = v;
   endtask

   task automatic check_all();
      check("out_valid", RW'(bus.out_valid), RW'(q.size() != 0));
      check("fill", RW'(bus.fill), RW'(q.size()));
      check("tiles_done", RW'(bus.tiles_done), RW'(m_tiles));
      check("overflow", RW'(bus.overflow), RW'(m_ovf));
      check("len_err", RW'(bus.len_err), RW'(m_len));
      if (q.size() > 0) begin
         check("out_data", bus.out_data, q[0].d);
         check("out_last", RW'(bus.out_last), RW'(q[0].last));
      end
   endtask

   // called just after a falling edge; returns after the next one
   task automatic step(input bit v, input bit df, input bit rdy,
                       input logic [RW-1:0] row);
      check_all();
      bus.in_valid  = v;
      bus.data_flow = df;
      bus.out_ready = rdy;
      bus.in_row    = row;
      #1;
      if (bus.out_valid && rdy) n_pops++;
      @(posedge clk);
      model_edge(v, df, rdy, row);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, rdy, '0);
   endtask

   task automatic do_reset();
      bus.in_valid = 0;
      rst = 1'b1;
      #1;
      check("rst_out_valid", RW'(bus.out_valid), '0);
      check("rst_out_last", RW'(bus.out_last), '0);
      check("rst_fill", RW'(bus.fill), '0);
      check("rst_tiles", RW'(bus.tiles_done), '0);
      check("rst_overflow", RW'(bus.overflow), '0);
      check("rst_len_err", RW'(bus.len_err), '0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   int base;

   initial begin
      bus.in_valid  = 0;
      bus.data_flow = 0;
      bus.out_ready = 0;
      bus.in_row    = '0;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset();

      // OS tile of 16 rows
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 1, mkrow(i));
         if (i == 0) check("lat_e0", RW'(bus.out_valid), '0);
         if (i == 1) check("lat_e1", RW'(bus.out_valid), RW'(1));
      end
      idle(4, 1);
      check("os_tiles", RW'(bus.tiles_done), RW'(1));
      check("os_len_err", RW'(bus.len_err), '0);

      // WS bursts of 5 and 3
      for (int i = 0; i < 5; i++) step(1, 1, 1, mkrow(100 + i));
      step(0, 1, 1, '0);
      for (int i = 0; i < 3; i++) step(1, 1, 1, mkrow(200 + i));
      idle(4, 1);
      check("ws_tiles", RW'(bus.tiles_done), RW'(3));
      check("ws_len_err", RW'(bus.len_err), '0);

      // backpressure and overflow
      do_reset();
      for (int i = 0; i < 17; i++) step(1, 1, 0, mkrow(300 + i));
      step(0, 1, 0, '0);
      check("ovf_fill", RW'(bus.fill), RW'(16));
      check("ovf_flag", RW'(bus.overflow), RW'(1));
      base = n_pops;
      idle(18, 1);
      check("ovf_pops", RW'(n_pops - base), RW'(16));
      check("ovf_drained", RW'(bus.fill), '0);
      check("ovf_sticky", RW'(bus.overflow), RW'(1));

      // full with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 17; i++) step(1, 1, 0, mkrow(400 + i));
      for (int i = 0; i < 4; i++) step(1, 1, 1, mkrow(500 + i));
      check("full_fill", RW'(bus.fill), RW'(16));
      check("full_no_ovf", RW'(bus.overflow), '0);
      idle(20, 1);

      // short OS tile with data_flow toggling, then 20-row OS burst
      do_reset();
      for (int i = 0; i < 10; i++) step(1, i[0], 1, mkrow(600 + i));
      idle(2, 1);
      check("short_len_err", RW'(bus.len_err), RW'(1));
      check("short_tiles", RW'(bus.tiles_done), RW'(1));
      for (int i = 0; i < 20; i++) step(1, 0, 1, mkrow(700 + i));
      idle(4, 1);
      check("long_tiles", RW'(bus.tiles_done), RW'(3));

      // reset in the middle of a burst
      do_reset();
      for (int i = 0; i < 6; i++) step(1, 0, 0, mkrow(800 + i));
      #2;
      do_reset();
      base = n_pops;
      for (int i = 0; i < 16; i++) step(1, 0, 1, mkrow(900 + i));
      idle(4, 1);
      check("rst_burst_pops", RW'(n_pops - base), RW'(16));
      check("rst_burst_tiles", RW'(bus.tiles_done), RW'(1));
      check("rst_burst_len", RW'(bus.len_err), '0);

      // random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 8,
              $urandom_range(0, 3) == 0,
              (i % 100) < 60 ? $urandom_range(0, 3) != 0 :
                               $urandom_range(0, 3) == 0,
              mkrow(1000 + i));
      end
      idle(DEPTH + 4, 1);
      check_all();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
